// File: rtl/row_clear_scanner.sv
// Post-lock playfield pass: scans rows bottom-up, compacts full rows out of the
// row memory, zero-fills the vacated top rows and reports the lines cleared.
module row_clear_scanner #(
    parameter int ROWS        = 20,
    parameter int COLS        = 10,
    parameter int AW          = 5,
    parameter int HOLD_CYCLES = 2
) (
    input  logic            clock,
    input  logic            ctrl_reset,
    input  logic            piece_locked,
    input  logic [COLS-1:0] row_rdata,
    output logic            row_rd_en,
    output logic [AW-1:0]   row_raddr,
    output logic            row_wr_en,
    output logic [AW-1:0]   row_waddr,
    output logic [COLS-1:0] row_wdata,
    output logic [2:0]      addPoints,
    output logic [1:0]      fromGame,
    output logic            busy,
    output logic [15:0]     lines_total
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW-1:0] TOP_ROW   = AW'(ROWS - 1);
    localparam logic [AW-1:0] ZERO_A    = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EV   = 3'd2,
        S_CLR  = 3'd3,
        S_RPT  = 3'd4
    } state_t;

    state_t          r_state, w_state_nx;
    logic [AW-1:0]   r_rd_ptr, w_rd_ptr_nx;
    logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nx;
    logic [2:0]      r_cnt, w_cnt_nx;
    logic [HW-1:0]   r_hold, w_hold_nx;
    logic            r_top_nz, w_top_nz_nx;
    logic            r_rd_en, w_rd_en_nx;
    logic [AW-1:0]   r_raddr, w_raddr_nx;
    logic            r_wr_en, w_wr_en_nx;
    logic [AW-1:0]   r_waddr, w_waddr_nx;
    logic [COLS-1:0] r_wdata, w_wdata_nx;
    logic [2:0]      r_add, w_add_nx;
    logic            r_fg0, w_fg0_nx;
    logic            r_fg1, w_fg1_nx;
    logic            r_busy, w_busy_nx;
    logic [15:0]     r_lines, w_lines_nx;
    logic            w_full;
    logic [16:0]     w_lt_sum;

    // FSM state register
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state_nx  = r_state;
        w_rd_ptr_nx = r_rd_ptr;
        w_wr_ptr_nx = r_wr_ptr;
        w_cnt_nx    = r_cnt;
        w_hold_nx   = r_hold;
        w_top_nz_nx = r_top_nz;
        w_rd_en_nx  = 1'b0;
        w_raddr_nx  = r_raddr;
        w_wr_en_nx  = 1'b0;
        w_waddr_nx  = r_waddr;
        w_wdata_nx  = r_wdata;
        w_add_nx    = r_add;
        w_fg0_nx    = 1'b0;
        w_fg1_nx    = r_fg1;
        w_lines_nx  = r_lines;
        w_full      = &row_rdata;
        w_lt_sum    = {1'b0, r_lines} + {14'd0, r_cnt};

        case (r_state)
            S_IDLE: begin
                if (piece_locked) begin
                    w_state_nx  = S_RD;
                    w_rd_ptr_nx = TOP_ROW;
                    w_wr_ptr_nx = TOP_ROW;
                    w_cnt_nx    = 3'd0;
                    w_rd_en_nx  = 1'b1;
                    w_raddr_nx  = TOP_ROW;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RD: begin
                w_state_nx = S_EV;
            end
            S_EV: begin
                if (w_full) begin
                    w_cnt_nx = (r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1;
                end else begin
                    // Rows already in place are not rewritten
                    if (r_wr_ptr != r_rd_ptr) begin
                        w_wr_en_nx = 1'b1;
                        w_waddr_nx = r_wr_ptr;
                        w_wdata_nx = row_rdata;
                    end else begin
                        w_wr_en_nx = 1'b0;
                    end
                    if (r_wr_ptr != ZERO_A) begin
                        w_wr_ptr_nx = r_wr_ptr - ONE_A;
                    end else begin
                        w_wr_ptr_nx = r_wr_ptr;
                    end
                end
                if (r_rd_ptr == ZERO_A) begin
                    w_top_nz_nx = (row_rdata != {COLS{1'b0}}) && !w_full;
                    if (w_cnt_nx != 3'd0) begin
                        w_state_nx = S_CLR;
                    end else begin
                        w_state_nx = S_RPT;
                        w_hold_nx  = {HW{1'b0}};
                    end
                end else begin
                    w_rd_ptr_nx = r_rd_ptr - ONE_A;
                    w_state_nx  = S_RD;
                    w_rd_en_nx  = 1'b1;
                    w_raddr_nx  = r_rd_ptr - ONE_A;
                end
            end
            S_CLR: begin
                // wr_ptr now marks the topmost vacated row; zero down to row 0
                w_wr_en_nx = 1'b1;
                w_waddr_nx = r_wr_ptr;
                w_wdata_nx = {COLS{1'b0}};
                if (r_wr_ptr == ZERO_A) begin
                    w_state_nx = S_RPT;
                    w_hold_nx  = HOLD_LOAD;
                    w_add_nx   = r_cnt;
                    w_fg0_nx   = 1'b1;
                    w_lines_nx = w_lt_sum[16] ? 16'hFFFF : w_lt_sum[15:0];
                end else begin
                    w_wr_ptr_nx = r_wr_ptr - ONE_A;
                end
            end
            S_RPT: begin
                if (r_hold != {HW{1'b0}}) begin
                    w_hold_nx = r_hold - HOLD_ONE;
                    w_fg0_nx  = r_fg0;
                end else begin
                    w_state_nx = S_IDLE;
                    w_fg1_nx   = r_fg1 | ((r_cnt == 3'd0) && r_top_nz);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_cnt    <= 3'd0;
            r_hold   <= {HW{1'b0}};
            r_top_nz <= 1'b0;
            r_rd_en  <= 1'b0;
            r_raddr  <= {AW{1'b0}};
            r_wr_en  <= 1'b0;
            r_waddr  <= {AW{1'b0}};
            r_wdata  <= {COLS{1'b0}};
            r_add    <= 3'd0;
            r_fg0    <= 1'b0;
            r_fg1    <= 1'b0;
            r_busy   <= 1'b0;
            r_lines  <= 16'd0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nx;
            r_wr_ptr <= w_wr_ptr_nx;
            r_cnt    <= w_cnt_nx;
            r_hold   <= w_hold_nx;
            r_top_nz <= w_top_nz_nx;
            r_rd_en  <= w_rd_en_nx;
            r_raddr  <= w_raddr_nx;
            r_wr_en  <= w_wr_en_nx;
            r_waddr  <= w_waddr_nx;
            r_wdata  <= w_wdata_nx;
            r_add    <= w_add_nx;
            r_fg0    <= w_fg0_nx;
            r_fg1    <= w_fg1_nx;
            r_busy   <= w_busy_nx;
            r_lines  <= w_lines_nx;
        end
    end

    assign row_rd_en   = r_rd_en;
    assign row_raddr   = r_raddr;
    assign row_wr_en   = r_wr_en;
    assign row_waddr   = r_waddr;
    assign row_wdata   = r_wdata;
    assign addPoints   = r_add;
    assign fromGame    = {r_fg1, r_fg0};
    assign busy        = r_busy;
    assign lines_total = r_lines;

endmodule

// File: tb/tb_row_clear_scanner.sv
// Directed bench for row_clear_scanner with a behavioural row memory and
// per-scan activity counters.
module tb_row_clear_scanner;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int AW   = 5;

    logic            clock = 1'b0;
    logic            ctrl_reset;
    logic            piece_locked;
    logic [COLS-1:0] row_rdata;
    logic            row_rd_en;
    logic [AW-1:0]   row_raddr;
    logic            row_wr_en;
    logic [AW-1:0]   row_waddr;
    logic [COLS-1:0] row_wdata;
    logic [2:0]      addPoints;
    logic [1:0]      fromGame;
    logic            busy;
    logic [15:0]     lines_total;

    logic [COLS-1:0] mem     [ROWS];
    logic [COLS-1:0] board   [ROWS];
    logic [COLS-1:0] exp_mem [ROWS];
    logic            load_req;
    logic [2:0]      exp_ap;
    logic            fg0_prev;
    int rd_cnt, wr_cnt, fg0_cnt, busy_cnt, reports, collisions, ap_bad, first_raddr;
    int n_err, n_chk, lat;
    bit found;

    always #5 clock = ~clock;

    row_clear_scanner #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .HOLD_CYCLES(2)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .piece_locked(piece_locked),
        .row_rdata(row_rdata), .row_rd_en(row_rd_en), .row_raddr(row_raddr),
        .row_wr_en(row_wr_en), .row_waddr(row_waddr), .row_wdata(row_wdata),
        .addPoints(addPoints), .fromGame(fromGame), .busy(busy),
        .lines_total(lines_total)
    );

    // Row memory with 1-cycle read latency, plus activity counters
    always @(posedge clock) begin
        if (load_req) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= board[i];
            rd_cnt <= 0; wr_cnt <= 0; fg0_cnt <= 0; busy_cnt <= 0;
            reports <= 0; collisions <= 0; ap_bad <= 0; first_raddr <= -1;
        end else begin
            if (row_wr_en) mem[row_waddr] <= row_wdata;
            if (row_rd_en) begin
                row_rdata <= mem[row_raddr];
                if (rd_cnt == 0) first_raddr <= int'(row_raddr);
            end
            rd_cnt     <= rd_cnt + int'(row_rd_en);
            wr_cnt     <= wr_cnt + int'(row_wr_en);
            fg0_cnt    <= fg0_cnt + int'(fromGame[0]);
            busy_cnt   <= busy_cnt + int'(busy);
            reports    <= reports + int'(fromGame[0] && !fg0_prev);
            collisions <= collisions + int'(row_rd_en && row_wr_en && (row_raddr == row_waddr));
            ap_bad     <= ap_bad + int'(fromGame[0] && (addPoints != exp_ap));
        end
        fg0_prev <= fromGame[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_board;
        for (int i = 0; i < ROWS; i++) begin
            board[i]   = 10'h000;
            exp_mem[i] = 10'h000;
        end
    endtask

    task automatic load_board;
        @(negedge clock);
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < ROWS; i++)
            chk($sformatf("%s_row%0d", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    // Starts a scan at the current negedge; optionally pulses piece_locked while busy
    task automatic run_scan(input bit extra, output int latency);
        int  k;
        bit  done;
        latency = 0;
        done = 1'b0;
        piece_locked = 1'b1;
        for (k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (!busy) begin
                piece_locked = 1'b0;
                done = 1'b1;
                break;
            end
            piece_locked = extra && (k == 3 || k == 4 || k == 42 || k == 45 || k == 46);
            if (latency == 0 && fromGame[0]) latency = k;
        end
        piece_locked = 1'b0;
        chk("scan_done", 32'(done), 32'd1);
    endtask

    task automatic board_one_line;
        clear_board();
        board[19] = 10'h3FF; board[18] = 10'h001;
        exp_mem[19] = 10'h001;
    endtask

    task automatic board_four_lines;
        clear_board();
        for (int i = 16; i < 20; i++) board[i] = 10'h3FF;
        board[15] = 10'h200;
        exp_mem[19] = 10'h200;
    endtask

    initial begin
        n_err = 0; n_chk = 0;
        ctrl_reset = 1'b1; piece_locked = 1'b0; load_req = 1'b0; exp_ap = 3'd0;
        clear_board();
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fromGame", 32'(fromGame), 32'd0);
        chk("rst_lines", 32'(lines_total), 32'd0);
        chk("rst_addPoints", 32'(addPoints), 32'd0);
        chk("rst_rd_en", 32'(row_rd_en), 32'd0);
        chk("rst_wr_en", 32'(row_wr_en), 32'd0);
        @(negedge clock);
        ctrl_reset = 1'b0;

        // Empty board
        load_board();
        run_scan(1'b0, lat);
        chk("empty_reads", 32'(rd_cnt), 32'd20);
        chk("empty_writes", 32'(wr_cnt), 32'd0);
        chk("empty_fg0", 32'(fg0_cnt), 32'd0);
        chk("empty_busy", 32'(busy_cnt), 32'd41);
        chk("empty_fromGame", 32'(fromGame), 32'd0);
        chk("empty_addPoints", 32'(addPoints), 32'd0);

        // One full row at the bottom
        board_one_line(); exp_ap = 3'd1;
        load_board();
        run_scan(1'b0, lat);
        chk("one_latency", 32'(lat), 32'd42);
        chk("one_fg0_cycles", 32'(fg0_cnt), 32'd2);
        chk("one_reports", 32'(reports), 32'd1);
        chk("one_addPoints", 32'(addPoints), 32'd1);
        chk("one_ap_stable", 32'(ap_bad), 32'd0);
        chk("one_lines", 32'(lines_total), 32'd1);
        chk("one_fromGame", 32'(fromGame), 32'd0);
        chk("one_writes", 32'(wr_cnt), 32'd20);
        chk("one_busy", 32'(busy_cnt), 32'd43);
        chk("one_collide", 32'(collisions), 32'd0);
        chk_mem("one");

        // Four full rows
        board_four_lines(); exp_ap = 3'd4;
        load_board();
        run_scan(1'b0, lat);
        chk("four_latency", 32'(lat), 32'd45);
        chk("four_fg0_cycles", 32'(fg0_cnt), 32'd2);
        chk("four_addPoints", 32'(addPoints), 32'd4);
        chk("four_ap_stable", 32'(ap_bad), 32'd0);
        chk("four_lines", 32'(lines_total), 32'd5);
        chk("four_writes", 32'(wr_cnt), 32'd20);
        chk("four_busy", 32'(busy_cnt), 32'd46);
        chk_mem("four");

        // Occupied top row with nothing to clear: sticky top-out
        clear_board();
        board[0] = 10'h010; exp_mem[0] = 10'h010;
        load_board();
        run_scan(1'b0, lat);
        chk("top_writes", 32'(wr_cnt), 32'd0);
        chk("top_fg0", 32'(fg0_cnt), 32'd0);
        chk("top_fromGame", 32'(fromGame), 32'd2);
        chk("top_addPoints_kept", 32'(addPoints), 32'd4);
        chk("top_lines", 32'(lines_total), 32'd5);
        chk_mem("top");
        board_one_line(); exp_ap = 3'd1;
        load_board();
        run_scan(1'b0, lat);
        chk("sticky_fromGame", 32'(fromGame), 32'd2);
        chk("sticky_lines", 32'(lines_total), 32'd6);
        chk("sticky_fg0_cycles", 32'(fg0_cnt), 32'd2);

        // Reset during the row-10 evaluate cycle
        board_one_line();
        load_board();
        piece_locked = 1'b1;
        @(negedge clock);
        piece_locked = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (row_rd_en && row_raddr == 5'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("rst_row10_seen", 32'(found), 32'd1);
        @(posedge clock);
        #2 ctrl_reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fromGame", 32'(fromGame), 32'd0);
        chk("mid_rst_rd_en", 32'(row_rd_en), 32'd0);
        chk("mid_rst_wr_en", 32'(row_wr_en), 32'd0);
        chk("mid_rst_lines", 32'(lines_total), 32'd0);
        @(negedge clock);
        ctrl_reset = 1'b0;
        board_one_line(); exp_ap = 3'd1;
        load_board();
        run_scan(1'b0, lat);
        chk("restart_first_addr", 32'(first_raddr), 32'd19);
        chk("restart_lines", 32'(lines_total), 32'd1);
        chk("restart_addPoints", 32'(addPoints), 32'd1);
        chk("restart_fromGame", 32'(fromGame), 32'd0);
        chk_mem("restart");

        // piece_locked pulses while busy are ignored
        board_four_lines(); exp_ap = 3'd4;
        load_board();
        run_scan(1'b1, lat);
        chk("busy_pulse_reports", 32'(reports), 32'd1);
        chk("busy_pulse_busy", 32'(busy_cnt), 32'd46);
        chk("busy_pulse_lines", 32'(lines_total), 32'd5);
        chk_mem("busy_pulse");
        repeat (5) @(negedge clock);
        chk("busy_pulse_idle", 32'(busy), 32'd0);
        chk("busy_pulse_reads", 32'(rd_cnt), 32'd20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/row_clear_scanner.md
Name: row_clear_scanner

Overview:
- Tetris-side game logic stage directly upstream of the CPU register file.
- After a piece locks, it scans the playfield row memory bottom-to-top and drops full rows by compacting the rows above them downward.
- It then reports the number of lines cleared on addPoints/fromGame, which the register file loads into r29.
- It also raises a sticky top-out flag on fromGame[1].

Parameters:
- ROWS, 20, number of playfield rows; row 0 is the top.
- COLS, 10, bits per row; 1 = occupied cell.
- AW, 5, row address width; requires 2^AW >= ROWS.
- HOLD_CYCLES, 2, cycles that fromGame[0] stays asserted per report; must be >= 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- piece_locked  in  1  one-cycle start pulse; ignored unless in IDLE.
- row_rdata  in  COLS  row memory read data, valid the cycle after row_rd_en.
- row_rd_en  out  1  row memory read strobe.
- row_raddr  out  AW  row memory read address.
- row_wr_en  out  1  row memory write strobe.
- row_waddr  out  AW  row memory write address.
- row_wdata  out  COLS  row memory write data.
- addPoints  out  3  lines cleared by the last scan (1..4).
- fromGame  out  2  [0] points-valid strobe; [1] sticky game-over flag.
- busy  out  1  high in every state except IDLE.
- lines_total  out  16  running total of cleared lines; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. rd_ptr, wr_ptr, line count, hold counter, addPoints, fromGame, lines_total and all memory strobes/addresses/data go to 0.
- Reset mid-scan aborts the scan. A partially compacted board is acceptable; the game restarts after reset.
- Internal row memory reads are synchronous with 1-cycle latency. The block never reads and writes the same address in the same cycle.
- IDLE: on piece_locked=1, set rd_ptr=ROWS-1, wr_ptr=ROWS-1, cnt=0, go to RD.
- RD: row_rd_en=1, row_raddr=rd_ptr; go to EV.
- EV (row_rdata valid):
  - Full row (&row_rdata): cnt+=1, wr_ptr unchanged, no write.
  - Otherwise, if wr_ptr != rd_ptr: write row_rdata to wr_ptr (row_wr_en=1 this cycle). Then wr_ptr-=1.
  - Also otherwise, if wr_ptr == rd_ptr: no write, wr_ptr-=1.
  - If rd_ptr==0: latch top_nonfull_nonzero = (row_rdata!=0 && !full), then go to CLR.
  - Else: rd_ptr-=1, go to RD.
- Scan cost is 2 cycles per row.
- CLR: writes zeros to addresses cnt-1 down to 0, one per cycle; this equals the final wr_ptr+1 rows. Skipped when cnt==0. Then go to RPT.
- RPT:
  - If cnt!=0: addPoints=cnt, fromGame[0]=1 for exactly HOLD_CYCLES consecutive cycles, addPoints stable throughout; lines_total+=cnt (saturating) on the first cycle. Holding covers cycles where the register file is taking a CPU write and drops the game load.
  - If cnt==0: no strobe, addPoints keeps its old value.
  - Then go to IDLE.
- fromGame[1]: set in RPT when cnt==0 and top_nonfull_nonzero (row 0 occupied after compaction). Cleared only by reset.
- Counts: cnt never exceeds 4 in normal play. It is a 3-bit saturating counter; 7 is the max reported.
- Latency: piece_locked to first fromGame[0] = 2*ROWS + cnt + 1 cycles; for ROWS=20, cnt=1 that is 42.
- piece_locked while busy: ignored, not queued.
- wr_ptr must not underflow: every non-full row consumes exactly one destination slot, so it ends at cnt-1.
- Outputs are registered; row_wr_en, row_rd_en and fromGame[0] deassert in IDLE.

Test Plan:
- Empty board, piece_locked -> 20 reads, 0 writes, no fromGame[0], busy high 41 cycles, fromGame=2'b00.
- Row 19 full (10'h3FF), row 18=10'h001, rest 0:
  - row 19 <- 10'h001; rows 18..0 zero-written only at CLR addr 0 and copies as computed.
  - addPoints=3'd1, fromGame[0] high exactly 2 cycles, lines_total=1.
- Rows 16..19 full, row 15=10'h200 -> row 19 <- 10'h200, CLR writes 0 to addr 3..0, addPoints=3'd4, lines_total +4.
- Row 0=10'h010, no full rows -> no writes, no strobe, fromGame[1]=1 and stays 1 across further scans until ctrl_reset.
- Assert ctrl_reset during row 10 EV -> same-cycle asynchronous clear: busy=0, fromGame=0, strobes 0. Next piece_locked starts a fresh scan from row 19.
- piece_locked pulses during RD/EV/CLR/RPT -> no effect; exactly one report per accepted start.
